// File: rtl/addsub_sequencer.sv
// addsub_sequencer: request queue -> external synchronous add/sub stage -> result queue.
// Issue is credit-limited so the result queue can never overflow while the consumer stalls.
module addsub_sequencer #(
  parameter int unsigned sAddWidth = 8,
  parameter int unsigned qDepth    = 4
) (
  input  logic                 adderClock,
  input  logic                 resetNeg,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic [sAddWidth-1:0] reqA,
  input  logic [sAddWidth-1:0] reqB,
  input  logic                 reqOpSel,
  output logic [sAddWidth-1:0] numA,
  output logic [sAddWidth-1:0] numB,
  output logic                 opSelect,
  input  logic [sAddWidth-1:0] sumFinal,
  input  logic                 overflowBit,
  input  logic                 carryOut,
  output logic                 resValid,
  input  logic                 resReady,
  output logic [sAddWidth-1:0] resSum,
  output logic                 resOverflow,
  output logic                 resCarry,
  output logic [2:0]           inFlight
);

  localparam int unsigned AW    = $clog2(qDepth);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned SW    = ((CW > 3) ? CW : 3) + 1;
  localparam int unsigned REQ_W = 2 * sAddWidth + 1;
  localparam int unsigned RES_W = sAddWidth + 2;
  localparam logic [CW-1:0] FULL_CNT = CW'(qDepth);

  // Request queue: {a, b, op}
  logic [REQ_W-1:0] req_mem [qDepth];
  logic [AW-1:0]    req_wr;
  logic [AW-1:0]    req_rd;
  logic [CW-1:0]    req_cnt;
  logic [AW-1:0]    req_wr_n;
  logic [AW-1:0]    req_rd_n;
  logic [CW-1:0]    req_cnt_n;
  logic [REQ_W-1:0] req_head;

  // Result queue: {sum, overflow, carry}
  logic [RES_W-1:0] res_mem   [qDepth];
  logic [RES_W-1:0] res_mem_n [qDepth];
  logic [AW-1:0]    res_wr;
  logic [AW-1:0]    res_rd;
  logic [CW-1:0]    res_cnt;
  logic [AW-1:0]    res_wr_n;
  logic [AW-1:0]    res_rd_n;
  logic [CW-1:0]    res_cnt_n;
  logic [RES_W-1:0] res_head_n;

  // Issue pipeline tracking
  logic [2:0]    vpipe;
  logic [2:0]    vpipe_n;
  logic [2:0]    inflight_n;
  logic          op_pipe;
  logic          carry_pipe;
  logic [SW-1:0] credit_used;

  logic req_push;
  logic issue;
  logic res_push;
  logic res_pop;

  // Handshakes, credit check and next-state for both queues and the tag pipe
  always_comb begin
    req_push    = reqValid && reqReady;
    credit_used = SW'(res_cnt) + SW'(inFlight);
    // Uses pre-edge result count: a same-edge pop never frees a credit early
    issue       = (req_cnt != '0) && (credit_used < SW'(qDepth));
    res_push    = vpipe[2];
    res_pop     = resValid && resReady;
    req_head    = req_mem[req_rd];

    req_wr_n  = req_push ? (req_wr + AW'(1)) : req_wr;
    req_rd_n  = issue    ? (req_rd + AW'(1)) : req_rd;
    req_cnt_n = req_cnt + CW'(req_push) - CW'(issue);

    res_mem_n = res_mem;
    if (res_push) begin
      res_mem_n[res_wr] = {sumFinal, overflowBit, carry_pipe};
    end
    res_wr_n   = res_push ? (res_wr + AW'(1)) : res_wr;
    res_rd_n   = res_pop  ? (res_rd + AW'(1)) : res_rd;
    res_cnt_n  = res_cnt + CW'(res_push) - CW'(res_pop);
    res_head_n = res_mem_n[res_rd_n];

    vpipe_n    = {vpipe[1:0], issue};
    inflight_n = 3'(vpipe_n[0]) + 3'(vpipe_n[1]) + 3'(vpipe_n[2]);
  end

  // Request queue storage and pointers
  always_ff @(posedge adderClock) begin
    if (!resetNeg) begin
      req_mem  <= '{default: '0};
      req_wr   <= '0;
      req_rd   <= '0;
      req_cnt  <= '0;
      reqReady <= 1'b1;
    end else begin
      if (req_push) begin
        req_mem[req_wr] <= {reqA, reqB, reqOpSel};
      end
      req_wr   <= req_wr_n;
      req_rd   <= req_rd_n;
      req_cnt  <= req_cnt_n;
      reqReady <= (req_cnt_n != FULL_CNT);
    end
  end

  // Operand registers loaded on issue; op held one edge so it lines up with the stage's operand register
  always_ff @(posedge adderClock) begin
    if (!resetNeg) begin
      numA    <= '0;
      numB    <= '0;
      op_pipe <= 1'b0;
    end else if (issue) begin
      numA    <= req_head[REQ_W-1 -: sAddWidth];
      numB    <= req_head[sAddWidth:1];
      op_pipe <= req_head[0];
    end
  end

  // Tag pipe, delayed op select and carry capture
  always_ff @(posedge adderClock) begin
    if (!resetNeg) begin
      vpipe      <= '0;
      inFlight   <= '0;
      opSelect   <= 1'b0;
      carry_pipe <= 1'b0;
    end else begin
      vpipe    <= vpipe_n;
      inFlight <= inflight_n;
      if (vpipe[0]) begin
        opSelect <= op_pipe;
      end
      if (vpipe[1]) begin
        carry_pipe <= carryOut;
      end
    end
  end

  // Result queue storage, pointers and registered head-of-queue outputs
  always_ff @(posedge adderClock) begin
    if (!resetNeg) begin
      res_mem     <= '{default: '0};
      res_wr      <= '0;
      res_rd      <= '0;
      res_cnt     <= '0;
      resValid    <= 1'b0;
      resSum      <= '0;
      resOverflow <= 1'b0;
      resCarry    <= 1'b0;
    end else begin
      res_mem     <= res_mem_n;
      res_wr      <= res_wr_n;
      res_rd      <= res_rd_n;
      res_cnt     <= res_cnt_n;
      resValid    <= (res_cnt_n != '0);
      resSum      <= res_head_n[RES_W-1 -: sAddWidth];
      resOverflow <= res_head_n[1];
      resCarry    <= res_head_n[0];
    end
  end

endmodule

// File: tb/tb_addsub_sequencer.sv
// Testbench for addsub_sequencer: directed vector table plus multi-cycle corner sequences.
// Includes a behavioural model of the downstream synchronous add/sub stage.
module tb_addsub_sequencer;

  localparam int W  = 8;
  localparam int NV = 10;

  logic         adderClock = 1'b0;
  logic         resetNeg;
  logic         reqValid;
  logic         reqReady;
  logic [W-1:0] reqA;
  logic [W-1:0] reqB;
  logic         reqOpSel;
  logic [W-1:0] numA;
  logic [W-1:0] numB;
  logic         opSelect;
  logic [W-1:0] sumFinal;
  logic         overflowBit;
  logic         carryOut;
  logic         resValid;
  logic         resReady;
  logic [W-1:0] resSum;
  logic         resOverflow;
  logic         resCarry;
  logic [2:0]   inFlight;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [W-1:0] sum;
    logic         ovf;
    logic         cy;
  } vec_t;

  vec_t tab [NV];

  int checks = 0;
  int errors = 0;
  int sent   = 0;
  int got    = 0;
  int n_send = 0;

  addsub_sequencer #(.sAddWidth(W), .qDepth(4)) dut (
    .adderClock (adderClock),
    .resetNeg   (resetNeg),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .reqA       (reqA),
    .reqB       (reqB),
    .reqOpSel   (reqOpSel),
    .numA       (numA),
    .numB       (numB),
    .opSelect   (opSelect),
    .sumFinal   (sumFinal),
    .overflowBit(overflowBit),
    .carryOut   (carryOut),
    .resValid   (resValid),
    .resReady   (resReady),
    .resSum     (resSum),
    .resOverflow(resOverflow),
    .resCarry   (resCarry),
    .inFlight   (inFlight)
  );

  always #5 adderClock = ~adderClock;

  // Add/sub stage model: registers operands, carry combinational on them, sum/overflow registered
  function automatic logic [9:0] calc(input logic [7:0] a, input logic [7:0] b, input logic op);
    logic [7:0] bb;
    logic [8:0] r;
    logic       ovf;
    bb  = op ? ~b : b;
    r   = {1'b0, a} + {1'b0, bb} + 9'(op);
    ovf = (a[7] == bb[7]) && (r[7] != a[7]);
    return {ovf, r};
  endfunction

  logic [7:0] a_r   = 8'h00;
  logic [7:0] b_r   = 8'h00;
  logic [7:0] sum_r = 8'h00;
  logic       ovf_r = 1'b0;
  logic [9:0] cur;

  assign cur         = calc(a_r, b_r, opSelect);
  assign carryOut    = cur[8];
  assign sumFinal    = sum_r;
  assign overflowBit = ovf_r;

  always @(posedge adderClock) begin
    a_r   <= numA;
    b_r   <= numB;
    sum_r <= cur[7:0];
    ovf_r <= cur[9];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge adderClock);
    @(negedge adderClock);
  endtask

  task automatic do_reset();
    resetNeg = 1'b0;
    reqValid = 1'b0;
    resReady = 1'b0;
    tick();
    tick();
    resetNeg = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_reqReady"}, 32'(reqReady), 32'd1);
    chk({tag, "_resValid"}, 32'(resValid), 32'd0);
    chk({tag, "_numA"}, 32'(numA), 32'd0);
    chk({tag, "_numB"}, 32'(numB), 32'd0);
    chk({tag, "_opSelect"}, 32'(opSelect), 32'd0);
    chk({tag, "_resSum"}, 32'(resSum), 32'd0);
    chk({tag, "_resOverflow"}, 32'(resOverflow), 32'd0);
    chk({tag, "_resCarry"}, 32'(resCarry), 32'd0);
    chk({tag, "_inFlight"}, 32'(inFlight), 32'd0);
  endtask

  // One cycle: offer the next request, pop/check the head if resReady, advance one edge
  task automatic step(input logic rr);
    logic acc;
    vec_t v;
    resReady = rr;
    reqValid = (sent < n_send);
    v        = tab[sent % NV];
    reqA     = v.a;
    reqB     = v.b;
    reqOpSel = v.op;
    acc      = reqValid && reqReady;
    if (resValid && rr) begin
      v = tab[got % NV];
      chk("res_sum", 32'(resSum), 32'(v.sum));
      chk("res_ovf", 32'(resOverflow), 32'(v.ovf));
      chk("res_carry", 32'(resCarry), 32'(v.cy));
      got++;
    end
    tick();
    if (acc) sent++;
  endtask

  // Single isolated operation with exact latency and opSelect alignment checks
  task automatic single(input int i, input logic prev_op);
    vec_t v;
    v        = tab[i];
    resReady = 1'b0;
    reqValid = 1'b1;
    reqA     = v.a;
    reqB     = v.b;
    reqOpSel = v.op;
    tick();                                   // Ea
    reqValid = 1'b0;
    chk("lat_ea_valid", 32'(resValid), 32'd0);
    tick();                                   // Ea+1: issue
    chk("issue_numA", 32'(numA), 32'(v.a));
    chk("issue_numB", 32'(numB), 32'(v.b));
    chk("issue_op_held", 32'(opSelect), 32'(prev_op));
    chk("issue_inflight", 32'(inFlight), 32'd1);
    tick();                                   // Ea+2
    chk("opsel_loaded", 32'(opSelect), 32'(v.op));
    tick();                                   // Ea+3
    chk("lat_ea3_valid", 32'(resValid), 32'd0);
    tick();                                   // Ea+4
    chk("lat_ea4_valid", 32'(resValid), 32'd1);
    chk("single_sum", 32'(resSum), 32'(v.sum));
    chk("single_ovf", 32'(resOverflow), 32'(v.ovf));
    chk("single_carry", 32'(resCarry), 32'(v.cy));
    chk("single_inflight", 32'(inFlight), 32'd0);
    resReady = 1'b1;
    tick();
    resReady = 1'b0;
    chk("single_popped", 32'(resValid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d results", got);
    $fatal(1);
  end

  initial begin
    // a, b, op, sum, ovf, carry (hand-computed; ops alternate 0/1)
    tab[0] = {8'h7F, 8'h01, 1'b0, 8'h80, 1'b1, 1'b0};
    tab[1] = {8'h05, 8'h03, 1'b1, 8'h02, 1'b0, 1'b1};
    tab[2] = {8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1};
    tab[3] = {8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0};
    tab[4] = {8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tab[5] = {8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    tab[6] = {8'h3C, 8'h0A, 1'b0, 8'h46, 1'b0, 1'b0};
    tab[7] = {8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1};
    tab[8] = {8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};
    tab[9] = {8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};

    resetNeg = 1'b0;
    reqValid = 1'b0;
    resReady = 1'b0;
    reqA     = '0;
    reqB     = '0;
    reqOpSel = 1'b0;
    @(negedge adderClock);
    do_reset();
    check_reset("rst0");

    // Isolated operations: 7F+01, 05-03, 03-05
    single(0, 1'b0);
    single(1, 1'b0);
    single(3, 1'b1);

    // Back-to-back alternating ops with resReady held high
    sent   = 0;
    got    = 0;
    n_send = NV;
    for (int cyc = 0; cyc < 80 && got < NV; cyc++) begin
      if (cyc == 4) chk("stream_latency", 32'(resValid), 32'd0);
      if (cyc >= 5 && cyc <= 8) chk("stream_beat", 32'(resValid), 32'd1);
      step(1'b1);
    end
    reqValid = 1'b0;
    chk("stream_count", 32'(got), 32'(NV));

    // Consumer stalled with 12 requests offered
    do_reset();
    sent   = 0;
    got    = 0;
    n_send = 12;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step(1'b0);
      chk("stall_inflight_bound", 32'(inFlight <= 3'd3), 32'd1);
    end
    chk("stall_accepted", 32'(sent), 32'd8);
    chk("stall_reqReady", 32'(reqReady), 32'd0);
    chk("stall_resValid", 32'(resValid), 32'd1);
    chk("stall_inflight", 32'(inFlight), 32'd0);
    chk("stall_last_issued", 32'(numA), 32'(tab[3].a));
    chk("stall_head", 32'(resSum), 32'(tab[0].sum));

    // One pop: credit returns only on the following edge; full request queue refuses a push
    step(1'b1);
    chk("pop1_reqReady", 32'(reqReady), 32'd0);
    chk("pop1_inflight", 32'(inFlight), 32'd0);
    chk("pop1_resValid", 32'(resValid), 32'd1);
    step(1'b0);
    chk("pop2_reqReady", 32'(reqReady), 32'd1);
    chk("pop2_inflight", 32'(inFlight), 32'd1);

    // Release the consumer: every result must appear in order
    for (int cyc = 0; cyc < 120 && got < 12; cyc++) begin
      step(1'b1);
    end
    reqValid = 1'b0;
    chk("drain_count", 32'(got), 32'd12);
    chk("drain_sent", 32'(sent), 32'd12);

    // Reset with three operations in flight
    do_reset();
    sent   = 0;
    got    = 0;
    n_send = 3;
    for (int cyc = 0; cyc < 4; cyc++) begin
      step(1'b0);
    end
    chk("pre_rst_inflight", 32'(inFlight), 32'd3);
    resetNeg = 1'b0;
    tick();
    resetNeg = 1'b1;
    check_reset("rst_mid");
    resReady = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      chk("post_rst_no_result", 32'(resValid), 32'd0);
    end
    chk("post_rst_inflight", 32'(inFlight), 32'd0);
    chk("post_rst_numA", 32'(numA), 32'd0);
    resReady = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
